// File: rtl/down_counter_timer_if.sv
// Load/control/status bundle for down_counter_timer.
// master drives the load handshake and controls; slave is the timer itself.
interface down_counter_timer_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             en;
  logic             abort;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;

  modport master (
    output in_valid, in_data, en, abort,
    input  in_ready, count, busy, done
  );

  modport slave (
    input  in_valid, in_data, en, abort,
    output in_ready, count, busy, done
  );
endinterface

// File: rtl/down_counter_timer.sv
// Loadable down-counter with a one-cycle done pulse on reaching zero.
// Define DOWN_COUNTER_AUTORELOAD_EN to make it periodic (reload from the last loaded value).
module down_counter_timer #(
  parameter int WIDTH = 4
) (
  input logic                  clk,
  input logic                  rst,
  down_counter_timer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state, state_next;
  logic [WIDTH-1:0] count_q, count_next;
  logic             done_q, done_next;
  logic             accept;

`ifdef DOWN_COUNTER_AUTORELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_next;
`endif

  assign bus.in_ready = (state != RUN) && !rst;
  assign accept       = bus.in_valid && bus.in_ready;
  assign bus.count    = count_q;
  assign bus.busy     = (state == RUN);
  assign bus.done     = done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      count_q <= ZERO;
      done_q  <= 1'b0;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
      reload_q <= ZERO;
`endif
    end else begin
      state   <= state_next;
      count_q <= count_next;
      done_q  <= done_next;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
      reload_q <= reload_next;
`endif
    end
  end

  // Abort outranks en in RUN; a zero load skips RUN and goes straight to DONE.
  always_comb begin
    state_next = state;
    count_next = count_q;
    done_next  = 1'b0;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
    reload_next = accept ? bus.in_data : reload_q;
`endif
    case (state)
      IDLE, DONE: begin
        if (accept) begin
          count_next = bus.in_data;
          if (bus.in_data == ZERO) begin
            state_next = DONE;
            done_next  = 1'b1;
          end else begin
            state_next = RUN;
          end
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_next = IDLE;
          count_next = ZERO;
        end else if (bus.en) begin
          if (count_q == ONE) begin
            done_next = 1'b1;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
            count_next = reload_q;
`else
            count_next = ZERO;
            state_next = DONE;
`endif
          end else begin
            count_next = count_q - ONE;
          end
        end
      end
      default: begin
        state_next = IDLE;
        count_next = ZERO;
      end
    endcase
  end

endmodule
